// File: rtl/jacobi_cordic_pkg.sv
`default_nettype none
// ============================================================================
// jacobi_cordic_pkg
//   Shared constants and types for the Jacobi vectoring/rotation CORDICs.
// Revision: 1.0
// ============================================================================
package jacobi_cordic_pkg;

  localparam int LUT_WIDTH = 20;
  localparam int LUT_DEPTH = 32;

  // round(atan(2^-i)/pi * 2^19): binary angle where 2^19 LSB = pi
  localparam logic [LUT_WIDTH-1:0] ATAN_LUT [LUT_DEPTH] = '{
    20'd131072, 20'd77376, 20'd40884, 20'd20753, 20'd10417, 20'd5213,
    20'd2607,   20'd1304,  20'd652,   20'd326,   20'd163,   20'd81,
    20'd41,     20'd20,    20'd10,    20'd5,     20'd3,     20'd1,
    20'd1,      20'd0,     20'd0,     20'd0,     20'd0,     20'd0,
    20'd0,      20'd0,     20'd0,     20'd0,     20'd0,     20'd0,
    20'd0,      20'd0
  };

  localparam logic [17:0] CORDIC_GAIN_Q16 = 18'd107922;

  typedef logic signed [LUT_WIDTH-1:0] angle_t;

  typedef enum logic {
    CORDIC_VECTORING = 1'b0,
    CORDIC_ROTATION  = 1'b1
  } cordic_mode_e;

  // Rescales the 20-bit LUT entry to another binary-angle word width.
  function automatic logic [63:0] atan_scaled(input int idx, input int width);
    logic [63:0] v;
    if (idx > LUT_DEPTH - 1) begin
      v = '0;
    end else begin
      v = 64'(ATAN_LUT[idx[4:0]]);
    end
    if (width >= LUT_WIDTH) begin
      atan_scaled = v << (width - LUT_WIDTH);
    end else begin
      atan_scaled = v >> (LUT_WIDTH - width);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/jacobi_cordic_stage.sv
`default_nettype none
// ============================================================================
// jacobi_cordic_stage
//   One registered CORDIC micro-rotation (vectoring or rotation mode).
// Revision: 1.0
// ============================================================================
module jacobi_cordic_stage
  import jacobi_cordic_pkg::*;
#(
  parameter int           WIDTH      = 20,
  parameter int           DATA_WIDTH = 22,
  parameter int           TAG_WIDTH  = 6,
  parameter int           STAGE      = 0,
  parameter cordic_mode_e MODE       = CORDIC_VECTORING
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vld_i,
  input  logic [TAG_WIDTH-1:0]         tag_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  logic signed [DATA_WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0]             z_i,
  output logic                         vld_o,
  output logic [TAG_WIDTH-1:0]         tag_o,
  output logic signed [DATA_WIDTH-1:0] x_o,
  output logic signed [DATA_WIDTH-1:0] y_o,
  output logic [WIDTH-1:0]             z_o
);

  localparam logic [WIDTH-1:0] ATAN_I = WIDTH'(atan_scaled(STAGE, WIDTH));

  logic                         d_pos;
  logic signed [DATA_WIDTH-1:0] x_sh;
  logic signed [DATA_WIDTH-1:0] y_sh;
  logic signed [DATA_WIDTH-1:0] x_d;
  logic signed [DATA_WIDTH-1:0] y_d;
  logic [WIDTH-1:0]             z_d;
  logic signed [DATA_WIDTH-1:0] x_q;
  logic signed [DATA_WIDTH-1:0] y_q;
  logic [WIDTH-1:0]             z_q;
  logic                         vld_q;
  logic [TAG_WIDTH-1:0]         tag_q;

  // d=+1 drives y toward zero (vectoring) or z toward zero (rotation)
  always_comb begin
    d_pos = (MODE == CORDIC_VECTORING) ? y_i[DATA_WIDTH-1] : ~z_i[WIDTH-1];
    x_sh  = x_i >>> STAGE;
    y_sh  = y_i >>> STAGE;
    x_d   = x_i;
    y_d   = y_i;
    z_d   = z_i;
    if (d_pos) begin
      x_d = x_i - y_sh;
      y_d = y_i + x_sh;
      z_d = z_i - ATAN_I;
    end else begin
      x_d = x_i + y_sh;
      y_d = y_i - x_sh;
      z_d = z_i + ATAN_I;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      vld_q <= 1'b0;
      tag_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      vld_q <= vld_i;
      tag_q <= tag_i;
    end
  end

  assign x_o   = x_q;
  assign y_o   = y_q;
  assign z_o   = z_q;
  assign vld_o = vld_q;
  assign tag_o = tag_q;

endmodule
`default_nettype wire

// File: rtl/jacobi_vectoring_cordic.sv
`default_nettype none
// ============================================================================
// jacobi_vectoring_cordic
//   Pipelined vectoring CORDIC: magnitude, residual and z + atan2(y,x).
// Revision: 1.0
// ============================================================================
module jacobi_vectoring_cordic
  import jacobi_cordic_pkg::*;
#(
  parameter int WIDTH     = 20,
  parameter int N_ITER    = 16,
  parameter int GUARD     = 2,
  parameter int TAG_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] in_dat_x_i,
  input  logic signed [WIDTH-1:0] in_dat_y_i,
  input  logic signed [WIDTH-1:0] in_dat_z_i,
  input  logic                    in_vld_i,
  input  logic [TAG_WIDTH-1:0]    in_tag_i,
  output logic signed [WIDTH-1:0] out_dat_x_o,
  output logic signed [WIDTH-1:0] out_dat_y_o,
  output logic signed [WIDTH-1:0] out_dat_z_o,
  output logic                    out_vld_o,
  output logic [TAG_WIDTH-1:0]    out_tag_o
);

  localparam int DW = WIDTH + GUARD;

  logic signed [DW-1:0]    ext_x;
  logic signed [DW-1:0]    ext_y;
  logic signed [DW-1:0]    pre_x_d;
  logic signed [DW-1:0]    pre_y_d;
  logic [WIDTH-1:0]        pre_z_d;
  logic signed [DW-1:0]    pre_x_q;
  logic signed [DW-1:0]    pre_y_q;
  logic [WIDTH-1:0]        pre_z_q;
  logic                    pre_vld_q;
  logic [TAG_WIDTH-1:0]    pre_tag_q;

  logic signed [DW-1:0]    stg_x   [N_ITER+1];
  logic signed [DW-1:0]    stg_y   [N_ITER+1];
  logic [WIDTH-1:0]        stg_z   [N_ITER+1];
  logic [TAG_WIDTH-1:0]    stg_tag [N_ITER+1];
  logic [N_ITER:0]         stg_vld;

  logic [WIDTH-1:0]        out_x_d;
  logic [WIDTH-1:0]        out_y_d;
  logic [WIDTH-1:0]        out_x_q;
  logic [WIDTH-1:0]        out_y_q;
  logic [WIDTH-1:0]        out_z_q;
  logic                    out_vld_q;
  logic [TAG_WIDTH-1:0]    out_tag_q;

  function automatic logic [WIDTH-1:0] sat_word(input logic signed [DW-1:0] v);
    logic [GUARD:0] hi;
    hi = v[DW-1:WIDTH-1];
    if ((&hi) || !(|hi)) begin
      sat_word = v[WIDTH-1:0];
    end else if (v[DW-1]) begin
      sat_word = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sat_word = {1'b0, {(WIDTH-1){1'b1}}};
    end
  endfunction

  // Fold the left half-plane onto the right; the guard bits absorb -(-2^(W-1)).
  always_comb begin
    ext_x   = {{GUARD{in_dat_x_i[WIDTH-1]}}, in_dat_x_i};
    ext_y   = {{GUARD{in_dat_y_i[WIDTH-1]}}, in_dat_y_i};
    pre_x_d = ext_x;
    pre_y_d = ext_y;
    pre_z_d = in_dat_z_i;
    if (in_dat_x_i[WIDTH-1]) begin
      pre_x_d = -ext_x;
      pre_y_d = -ext_y;
      pre_z_d = in_dat_z_i ^ {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_x_q   <= '0;
      pre_y_q   <= '0;
      pre_z_q   <= '0;
      pre_vld_q <= 1'b0;
      pre_tag_q <= '0;
    end else begin
      pre_x_q   <= pre_x_d;
      pre_y_q   <= pre_y_d;
      pre_z_q   <= pre_z_d;
      pre_vld_q <= in_vld_i;
      pre_tag_q <= in_tag_i;
    end
  end

  assign stg_x[0]   = pre_x_q;
  assign stg_y[0]   = pre_y_q;
  assign stg_z[0]   = pre_z_q;
  assign stg_vld[0] = pre_vld_q;
  assign stg_tag[0] = pre_tag_q;

  for (genvar i = 0; i < N_ITER; i++) begin : g_stage
    jacobi_cordic_stage #(
      .WIDTH      (WIDTH),
      .DATA_WIDTH (DW),
      .TAG_WIDTH  (TAG_WIDTH),
      .STAGE      (i),
      .MODE       (CORDIC_VECTORING)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .vld_i (stg_vld[i]),
      .tag_i (stg_tag[i]),
      .x_i   (stg_x[i]),
      .y_i   (stg_y[i]),
      .z_i   (stg_z[i]),
      .vld_o (stg_vld[i+1]),
      .tag_o (stg_tag[i+1]),
      .x_o   (stg_x[i+1]),
      .y_o   (stg_y[i+1]),
      .z_o   (stg_z[i+1])
    );
  end

  always_comb begin
    out_x_d = sat_word(stg_x[N_ITER]);
    out_y_d = sat_word(stg_y[N_ITER]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_x_q   <= '0;
      out_y_q   <= '0;
      out_z_q   <= '0;
      out_vld_q <= 1'b0;
      out_tag_q <= '0;
    end else begin
      out_x_q   <= out_x_d;
      out_y_q   <= out_y_d;
      out_z_q   <= stg_z[N_ITER];
      out_vld_q <= stg_vld[N_ITER];
      out_tag_q <= stg_tag[N_ITER];
    end
  end

  assign out_dat_x_o = out_x_q;
  assign out_dat_y_o = out_y_q;
  assign out_dat_z_o = out_z_q;
  assign out_vld_o   = out_vld_q;
  assign out_tag_o   = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_jacobi_vectoring_cordic.sv
`default_nettype none
// ============================================================================
// tb_jacobi_vectoring_cordic
//   Randomized self-checking bench against an iterative and a float model.
// Revision: 1.0
// ============================================================================
module tb_jacobi_vectoring_cordic;

  localparam int  WIDTH     = 20;
  localparam int  N_ITER    = 16;
  localparam int  GUARD     = 2;
  localparam int  TAG_WIDTH = 6;
  localparam int  LAT       = N_ITER + 2;
  localparam real PI        = 3.14159265358979;
  localparam real GAIN      = 1.6467602581;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic signed [WIDTH-1:0] in_dat_x_i = '0;
  logic signed [WIDTH-1:0] in_dat_y_i = '0;
  logic signed [WIDTH-1:0] in_dat_z_i = '0;
  logic                    in_vld_i = 1'b0;
  logic [TAG_WIDTH-1:0]    in_tag_i = '0;
  logic signed [WIDTH-1:0] out_dat_x_o;
  logic signed [WIDTH-1:0] out_dat_y_o;
  logic signed [WIDTH-1:0] out_dat_z_o;
  logic                    out_vld_o;
  logic [TAG_WIDTH-1:0]    out_tag_o;

  always #5 clk = ~clk;

  jacobi_vectoring_cordic #(
    .WIDTH     (WIDTH),
    .N_ITER    (N_ITER),
    .GUARD     (GUARD),
    .TAG_WIDTH (TAG_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_dat_x_i  (in_dat_x_i),
    .in_dat_y_i  (in_dat_y_i),
    .in_dat_z_i  (in_dat_z_i),
    .in_vld_i    (in_vld_i),
    .in_tag_i    (in_tag_i),
    .out_dat_x_o (out_dat_x_o),
    .out_dat_y_o (out_dat_y_o),
    .out_dat_z_o (out_dat_z_o),
    .out_vld_o   (out_vld_o),
    .out_tag_o   (out_tag_o)
  );

  typedef struct {
    bit     vld;
    bit     flt;
    longint tag;
    longint ex;
    longint ey;
    longint ez;
    longint fx;
    longint fz;
  } exp_t;

  int     n_chk = 0;
  int     n_fail = 0;
  bit     cur_flt = 1'b0;
  longint atan_tab [N_ITER];
  exp_t   pipe_q [$];
  exp_t   e_new;
  exp_t   e_old;

  task automatic chk(input string name, input longint obs, input longint exp,
                     input longint tol, input bit wrap);
    longint diff;
    n_chk++;
    diff = obs - exp;
    if (wrap) begin
      diff = diff & 64'hFFFFF;
      if (diff >= 524288) diff = diff - 1048576;
    end
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (tol %0d) at %0t", name, obs, exp, tol, $time);
    end
  endtask

  function automatic longint wrap20(input longint v);
    longint r;
    r = v & 64'hFFFFF;
    if (r >= 524288) r = r - 1048576;
    return r;
  endfunction

  function automatic longint sat20(input longint v);
    if (v > 524287) return 524287;
    if (v < -524288) return -524288;
    return v;
  endfunction

  function automatic longint rnd(input real v);
    return longint'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
  endfunction

  // Iterative reference: half-plane fold, then N_ITER shift-add micro-rotations.
  function automatic void ref_exact(input longint x, input longint y, input longint z,
                                    output longint ox, output longint oy, output longint oz);
    longint xc, yc, zc, xn;
    xc = x; yc = y; zc = z;
    if (x < 0) begin
      xc = -x; yc = -y; zc = z + 524288;
    end
    for (int i = 0; i < N_ITER; i++) begin
      if (yc < 0) begin
        xn = xc - (yc >>> i); yc = yc + (xc >>> i); zc = zc - atan_tab[i];
      end else begin
        xn = xc + (yc >>> i); yc = yc - (xc >>> i); zc = zc + atan_tab[i];
      end
      xc = xn;
    end
    ox = sat20(xc); oy = sat20(yc); oz = wrap20(zc);
  endfunction

  initial begin
    real p;
    p = 1.0;
    for (int i = 0; i < N_ITER; i++) begin
      atan_tab[i] = rnd($atan(p) / PI * 524288.0);
      p = p / 2.0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      pipe_q.delete();
      chk("rst_vld", longint'(out_vld_o), 0, 0, 0);
      chk("rst_x",   longint'(out_dat_x_o), 0, 0, 0);
      chk("rst_y",   longint'(out_dat_y_o), 0, 0, 0);
      chk("rst_z",   longint'(out_dat_z_o), 0, 0, 0);
      chk("rst_tag", longint'(out_tag_o), 0, 0, 0);
    end else begin
      e_new.vld = in_vld_i;
      e_new.flt = cur_flt;
      e_new.tag = longint'(in_tag_i);
      ref_exact(longint'(in_dat_x_i), longint'(in_dat_y_i), longint'(in_dat_z_i),
                e_new.ex, e_new.ey, e_new.ez);
      e_new.fx = sat20(rnd(GAIN * $sqrt(real'(in_dat_x_i) * real'(in_dat_x_i) +
                                        real'(in_dat_y_i) * real'(in_dat_y_i))));
      e_new.fz = wrap20(rnd(real'(in_dat_z_i) +
                            $atan2(real'(in_dat_y_i), real'(in_dat_x_i)) * 524288.0 / PI));
      pipe_q.push_back(e_new);
      if (pipe_q.size() > LAT) begin
        e_old = pipe_q.pop_front();
        chk("out_vld", longint'(out_vld_o), longint'(e_old.vld), 0, 0);
        if (e_old.vld) begin
          chk("out_tag", longint'(out_tag_o), e_old.tag, 0, 0);
          chk("out_x", longint'(out_dat_x_o), e_old.ex, 0, 0);
          chk("out_y", longint'(out_dat_y_o), e_old.ey, 0, 0);
          chk("out_z", longint'(out_dat_z_o), e_old.ez, 0, 1);
          if (e_old.flt) begin
            chk("float_x", longint'(out_dat_x_o), e_old.fx, 40, 0);
            chk("float_y", longint'(out_dat_y_o), 0, 40, 0);
            chk("float_z", longint'(out_dat_z_o), e_old.fz, 16, 1);
          end
        end
      end else begin
        chk("idle_vld", longint'(out_vld_o), 0, 0, 0);
      end
    end
  end

  task automatic drive(input bit v, input longint x, input longint y, input longint z,
                       input int tag, input bit flt);
    @(posedge clk);
    #1;
    in_vld_i   = v;
    in_dat_x_i = WIDTH'(x);
    in_dat_y_i = WIDTH'(y);
    in_dat_z_i = WIDTH'(z);
    in_tag_i   = TAG_WIDTH'(tag);
    cur_flt    = flt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic drive_random(input int tag);
    real    r, th;
    longint z;
    r  = 262144.0 + real'($urandom_range(0, 257000));
    th = 2.0 * PI * real'($urandom_range(0, 65535)) / 65536.0;
    z  = longint'($urandom_range(0, 1048575)) - 524288;
    drive(1'b1, longint'($rtoi(r * $cos(th))), longint'($rtoi(r * $sin(th))), z, tag, 1'b1);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // Directed single samples, including the negation and saturation corners
    drive(1'b1, 1000, 0, 0, 5, 1'b0);          idle(3);
    drive(1'b1, 1000, 1000, 0, 6, 1'b0);       idle(3);
    drive(1'b1, -1000, 0, 0, 7, 1'b0);         idle(3);
    drive(1'b1, -1000, 0, 300000, 8, 1'b0);    idle(3);
    drive(1'b1, 524287, 524287, 0, 9, 1'b0);   idle(3);
    drive(1'b1, 0, 0, 12345, 10, 1'b0);        idle(3);
    drive(1'b1, -524288, 0, 0, 11, 1'b0);      idle(3);
    drive(1'b1, 0, -524288, -100000, 12, 1'b0);
    idle(LAT + 2);

    // Back-to-back random stream with a 3-cycle bubble after tag 31
    for (int t = 0; t < 64; t++) begin
      drive_random(t);
      if (t == 31) idle(3);
    end
    idle(LAT + 2);

    // Reset with three samples still in flight
    for (int t = 0; t < 5; t++) drive_random(40 + t);
    idle(1);
    seen = 0;
    for (int c = 0; c < 60 && seen < 2; c++) begin
      @(negedge clk);
      if (out_vld_o) seen++;
    end
    chk("emerged_before_reset", longint'(seen), 2, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
    drive_random(50);
    idle(LAT + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
